// File: rtl/lf_cmd_pkg.sv
// Shared definitions for the LF SPI command receiver: opcodes, reset defaults,
// frame geometry and controller state encoding.
package lf_cmd_pkg;

    localparam logic [3:0] CMD_SET_CONF       = 4'h1;
    localparam logic [3:0] CMD_SET_DIVISOR    = 4'h2;
    localparam logic [3:0] CMD_SET_USER_BYTE1 = 4'h3;

    localparam logic [7:0] CONF_RST         = 8'h00;
    localparam logic [7:0] DIVISOR_RST      = 8'd95;
    localparam logic [7:0] USER_BYTE1_RST   = 8'd127;
    localparam logic [7:0] CONF_EDGE_DETECT = 8'h01;

    localparam logic [4:0] FRAME_BITS  = 5'd16;
    localparam logic [4:0] BIT_CNT_MAX = 5'd17;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_DECODE = 2'd2
    } state_t;

    // Counter stops at 17 so any over-long frame still reads as "not 16".
    function automatic logic [4:0] bit_cnt_inc(input logic [4:0] cnt);
        return (cnt == BIT_CNT_MAX) ? cnt : cnt + 5'd1;
    endfunction

endpackage

// File: rtl/lf_spi_cmd_rx_if.sv
// SPI pins plus decoded register/strobe outputs of the LF command receiver.
interface lf_spi_cmd_rx_if;

    logic       spck;
    logic       ncs;
    logic       mosi;
    logic       miso;
    logic [7:0] conf_word;
    logic [7:0] divisor;
    logic [7:0] user_byte1;
    logic       conf_stb;
    logic       div_stb;
    logic       ub1_stb;
    logic       frame_err;

    modport master (
        output spck, ncs, mosi,
        input  miso, conf_word, divisor, user_byte1,
        input  conf_stb, div_stb, ub1_stb, frame_err
    );

    modport slave (
        input  spck, ncs, mosi,
        output miso, conf_word, divisor, user_byte1,
        output conf_stb, div_stb, ub1_stb, frame_err
    );

endinterface

// File: rtl/sync_edge.sv
// Two-flop synchronizer plus history flop; edges are reported as sync != history.
module sync_edge #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic pck0,
    input  logic nreset,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic s_p0, s_p1, hist_p2;

    always_ff @(posedge pck0) begin
        if (!nreset) begin
            s_p0    <= RST_VAL;
            s_p1    <= RST_VAL;
            hist_p2 <= RST_VAL;
        end else begin
            s_p0    <= din;
            s_p1    <= s_p0;
            hist_p2 <= s_p1;
        end
    end

    assign level = s_p1;
    assign rise  = s_p1 & ~hist_p2;
    assign fall  = ~s_p1 & hist_p2;

endmodule

// File: rtl/lf_spi_cmd_rx.sv
// Receives 16-bit SPI command frames, decodes them into the LF mode/divisor/user
// registers and streams {conf_word, user_byte1} back on miso.
module lf_spi_cmd_rx
    import lf_cmd_pkg::*;
(
    input  logic     pck0,
    input  logic     nreset,
    lf_spi_cmd_rx_if.slave bus
);

    logic spck_lvl, spck_rise, spck_fall;
    logic ncs_lvl, ncs_rise, ncs_fall;
    logic mosi_lvl, mosi_rise, mosi_fall;

    sync_edge #(.RST_VAL(1'b0)) u_sync_spck (
        .pck0(pck0), .nreset(nreset), .din(bus.spck),
        .level(spck_lvl), .rise(spck_rise), .fall(spck_fall)
    );
    sync_edge #(.RST_VAL(1'b1)) u_sync_ncs (
        .pck0(pck0), .nreset(nreset), .din(bus.ncs),
        .level(ncs_lvl), .rise(ncs_rise), .fall(ncs_fall)
    );
    sync_edge #(.RST_VAL(1'b0)) u_sync_mosi (
        .pck0(pck0), .nreset(nreset), .din(bus.mosi),
        .level(mosi_lvl), .rise(mosi_rise), .fall(mosi_fall)
    );

    state_t      state, state_nxt;
    logic [4:0]  bit_cnt;
    logic [15:0] shift_reg;
    logic [15:0] miso_sr;
    logic [7:0]  conf_q, div_q, ub1_q;
    logic        conf_stb_q, div_stb_q, ub1_stb_q, frame_err_q;
    logic [1:0]  flush_cnt;
    logic        armed;
    logic        load_en, shift_en, decode_en;
    logic [3:0]  opcode;
    logic [7:0]  data;

    assign opcode = shift_reg[15:12];
    assign data   = shift_reg[7:0];

    // The ncs synchronizer resets high, so a pin held low through reset would
    // look like a falling edge; frames are only accepted once ncs has been
    // seen high after the synchronizer has flushed.
    always_ff @(posedge pck0) begin
        if (!nreset) begin
            flush_cnt <= 2'd0;
            armed     <= 1'b0;
        end else begin
            if (flush_cnt != 2'd3)
                flush_cnt <= flush_cnt + 2'd1;
            if (flush_cnt == 2'd3 && ncs_lvl)
                armed <= 1'b1;
        end
    end

    always_ff @(posedge pck0) begin
        if (!nreset)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        load_en   = 1'b0;
        shift_en  = 1'b0;
        decode_en = 1'b0;
        case (state)
            ST_IDLE: begin
                if (ncs_fall && armed) begin
                    load_en   = 1'b1;
                    state_nxt = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (ncs_rise)
                    state_nxt = ST_DECODE;
                else if (spck_rise)
                    shift_en = 1'b1;
            end
            ST_DECODE: begin
                decode_en = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge pck0) begin
        if (!nreset) begin
            bit_cnt     <= 5'd0;
            shift_reg   <= 16'h0000;
            miso_sr     <= 16'h0000;
            conf_q      <= CONF_RST;
            div_q       <= DIVISOR_RST;
            ub1_q       <= USER_BYTE1_RST;
            conf_stb_q  <= 1'b0;
            div_stb_q   <= 1'b0;
            ub1_stb_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            conf_stb_q  <= 1'b0;
            div_stb_q   <= 1'b0;
            ub1_stb_q   <= 1'b0;
            frame_err_q <= 1'b0;
            if (load_en) begin
                bit_cnt <= 5'd0;
                miso_sr <= {conf_q, ub1_q};
            end
            if (shift_en) begin
                shift_reg <= {shift_reg[14:0], mosi_lvl};
                bit_cnt   <= bit_cnt_inc(bit_cnt);
                miso_sr   <= {miso_sr[14:0], 1'b0};
            end
            if (decode_en) begin
                if (bit_cnt == FRAME_BITS) begin
                    case (opcode)
                        CMD_SET_CONF: begin
                            conf_q     <= data;
                            conf_stb_q <= 1'b1;
                            // Selecting edge-detect mode restores the default threshold.
                            if (data == CONF_EDGE_DETECT)
                                ub1_q <= USER_BYTE1_RST;
                        end
                        CMD_SET_DIVISOR: begin
                            div_q     <= data;
                            div_stb_q <= 1'b1;
                        end
                        CMD_SET_USER_BYTE1: begin
                            ub1_q     <= data;
                            ub1_stb_q <= 1'b1;
                        end
                        default: ;
                    endcase
                end else begin
                    frame_err_q <= 1'b1;
                end
            end
        end
    end

    assign bus.miso       = miso_sr[15];
    assign bus.conf_word  = conf_q;
    assign bus.divisor    = div_q;
    assign bus.user_byte1 = ub1_q;
    assign bus.conf_stb   = conf_stb_q;
    assign bus.div_stb    = div_stb_q;
    assign bus.ub1_stb    = ub1_stb_q;
    assign bus.frame_err  = frame_err_q;

    logic unused_sigs;
    assign unused_sigs = ^{spck_lvl, spck_fall, mosi_rise, mosi_fall, shift_reg[11:8]};

endmodule

// File: tb/tb_lf_spi_cmd_rx.sv
// Bench for lf_spi_cmd_rx: directed and random SPI frames compared against a
// frame-level model of the register/strobe/readback behaviour.
module tb_lf_spi_cmd_rx;

    logic pck0;
    logic nreset;
    int   n_assert;
    int   n_fail;

    logic [7:0] exp_conf, exp_div, exp_ub1;

    lf_spi_cmd_rx_if bus ();

    lf_spi_cmd_rx dut (
        .pck0(pck0),
        .nreset(nreset),
        .bus(bus)
    );

    initial pck0 = 1'b0;
    always #5 pck0 = ~pck0;

    task automatic tick();
        @(posedge pck0);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_regs(input string tag);
        chk({tag, "_conf"}, {24'd0, bus.conf_word}, {24'd0, exp_conf});
        chk({tag, "_div"},  {24'd0, bus.divisor},   {24'd0, exp_div});
        chk({tag, "_ub1"},  {24'd0, bus.user_byte1}, {24'd0, exp_ub1});
    endtask

    // Sends the low nbits of bits MSB first. With ncs_wins the final spck rise
    // coincides with the ncs rise and must not count as a bit.
    task automatic send_frame(input logic [16:0] bits, input int nbits, input bit ncs_wins);
        logic [15:0] rb, rx, mask, word;
        logic [16:0] shifted;
        int eff, nb;
        bit e_conf, e_div, e_ub1, e_err;
        rb = {exp_conf, exp_ub1};
        rx = 16'h0000;
        eff = ncs_wins ? nbits - 1 : nbits;
        bus.ncs = 1'b0;
        repeat (6) tick();
        for (int i = 0; i < nbits; i++) begin
            bus.mosi = bits[nbits-1-i];
            repeat (4) tick();
            if (i < 16) rx[15-i] = bus.miso;
            else chk("miso_tail", {31'd0, bus.miso}, 32'd0);
            bus.spck = 1'b1;
            if (!(ncs_wins && i == nbits - 1)) begin
                repeat (4) tick();
                bus.spck = 1'b0;
            end
        end
        nb = (nbits < 16) ? nbits : 16;
        mask = 16'hFFFF << (16 - nb);
        chk("miso_readback", {16'd0, rx}, {16'd0, rb & mask});
        if (!ncs_wins) repeat (4) tick();
        if (nbits == 16 && !ncs_wins)
            chk("miso_after16", {31'd0, bus.miso}, 32'd0);

        shifted = bits >> (nbits - eff);
        word    = shifted[15:0];
        e_err   = (eff != 16);
        e_conf  = !e_err && word[15:12] == 4'h1;
        e_div   = !e_err && word[15:12] == 4'h2;
        e_ub1   = !e_err && word[15:12] == 4'h3;

        bus.ncs = 1'b1;
        for (int c = 1; c <= 7; c++) begin
            tick();
            chk("conf_stb",  {31'd0, bus.conf_stb},  {31'd0, (c == 4) && e_conf});
            chk("div_stb",   {31'd0, bus.div_stb},   {31'd0, (c == 4) && e_div});
            chk("ub1_stb",   {31'd0, bus.ub1_stb},   {31'd0, (c == 4) && e_ub1});
            chk("frame_err", {31'd0, bus.frame_err}, {31'd0, (c == 4) && e_err});
        end
        if (e_conf) begin
            exp_conf = word[7:0];
            if (word[7:0] == 8'h01) exp_ub1 = 8'd127;
        end
        if (e_div) exp_div = word[7:0];
        if (e_ub1) exp_ub1 = word[7:0];
        chk_regs("regs");
        bus.spck = 1'b0;
        repeat (4) tick();
    endtask

    initial begin
        logic [15:0] w;
        int r;
        n_assert = 0;
        n_fail   = 0;
        bus.spck = 1'b0;
        bus.ncs  = 1'b1;
        bus.mosi = 1'b0;
        nreset   = 1'b0;
        exp_conf = 8'h00;
        exp_div  = 8'd95;
        exp_ub1  = 8'd127;
        repeat (4) tick();
        chk_regs("reset");
        chk("reset_miso", {31'd0, bus.miso}, 32'd0);
        nreset = 1'b1;
        for (int c = 0; c < 8; c++) begin
            tick();
            chk("idle_stbs", {28'd0, bus.conf_stb, bus.div_stb, bus.ub1_stb, bus.frame_err}, 32'd0);
        end
        chk_regs("idle");
        chk("idle_miso", {31'd0, bus.miso}, 32'd0);

        send_frame({1'b0, 16'h2060}, 16, 1'b0);
        send_frame({1'b0, 16'h3050}, 16, 1'b0);
        send_frame({1'b0, 16'h1001}, 16, 1'b0);
        send_frame({2'b0, 15'(16'h1020 >> 1)}, 15, 1'b0);
        send_frame({16'h1020, 1'b0}, 17, 1'b0);
        send_frame({1'b0, 16'h7055}, 16, 1'b0);
        send_frame({1'b0, 16'h1021}, 16, 1'b0);
        send_frame({1'b0, 16'h3080}, 16, 1'b0);
        send_frame({1'b0, 16'h7000}, 16, 1'b0);
        send_frame({1'b0, 16'h2033}, 16, 1'b1);

        // Reset in the middle of a frame with ncs held low throughout.
        w = 16'h20FF;
        bus.ncs = 1'b0;
        repeat (6) tick();
        for (int i = 0; i < 8; i++) begin
            bus.mosi = w[15-i];
            repeat (4) tick();
            bus.spck = 1'b1;
            repeat (4) tick();
            bus.spck = 1'b0;
        end
        nreset = 1'b0;
        repeat (3) tick();
        nreset = 1'b1;
        exp_conf = 8'h00;
        exp_div  = 8'd95;
        exp_ub1  = 8'd127;
        repeat (8) tick();
        bus.ncs = 1'b1;
        for (int c = 0; c < 8; c++) begin
            tick();
            chk("rst_mid_stbs", {28'd0, bus.conf_stb, bus.div_stb, bus.ub1_stb, bus.frame_err}, 32'd0);
        end
        chk_regs("rst_mid");
        repeat (4) tick();
        send_frame({1'b0, 16'h2011}, 16, 1'b0);

        for (int k = 0; k < 20; k++) begin
            w = {4'($urandom_range(0, 7)), 4'($urandom_range(0, 15)), 8'($urandom_range(0, 255))};
            r = $urandom_range(0, 9);
            if (r == 0)      send_frame({2'b0, w[15:1]}, 15, 1'b0);
            else if (r == 1) send_frame({w, 1'($urandom_range(0, 1))}, 17, 1'b0);
            else if (r == 2) send_frame({1'b0, w}, 16, 1'b1);
            else             send_frame({1'b0, w}, 16, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/lf_spi_cmd_rx.md
LF_SPI_CMD_RX -- requirements
Module: lf_spi_cmd_rx

Interface
REQ-001 SHALL have one clock and one reset; reset is synchronous and active-low.
REQ-002 pck0  in  1  sole clock; all state updates on rising edge.
REQ-003 nreset  in  1  synchronous active-low reset, sampled on pck0.
REQ-004 spck  in  1  SPI clock from ARM, asynchronous to pck0.
REQ-005 ncs  in  1  SPI chip select, active-low, asynchronous.
REQ-006 mosi  in  1  SPI data in, sampled on spck rising edge, MSB first.
REQ-007 miso  out  1  readback bit stream of {conf_word, user_byte1}, MSB first.
REQ-008 conf_word  out  8  mode word; [7:5] major mode, [1] edge toggle mode, [0] field enable.
REQ-009 divisor  out  8  pck0 divider value for the LF clock divider.
REQ-010 user_byte1  out  8  edge-detect threshold / user parameter.
REQ-011 conf_stb, div_stb, ub1_stb  out  1 each  one-cycle pulse when the matching register is written.
REQ-012 frame_err  out  1  one-cycle pulse on a malformed frame.

Function
REQ-013 spck, ncs, mosi SHALL each pass through a 2-flop synchronizer plus one history flop; edges are detected as sync2 != hist.
REQ-014 States: IDLE, SHIFT, DECODE; encoding from shared package.
REQ-015 IDLE -> SHIFT on detected ncs falling edge; bit_cnt cleared to 0, miso load register loaded with {conf_word, user_byte1}.
REQ-016 In SHIFT, each detected spck rising edge SHALL shift synchronized mosi into shift_reg[0] (shift_reg[15:1] <= shift_reg[14:0]), increment bit_cnt saturating at 17, and advance miso to the next readback bit.
REQ-017 miso SHALL present readback bit 15 after load; after the 16th spck rise it SHALL drive 0.
REQ-018 SHIFT -> DECODE on detected ncs rising edge; DECODE SHALL last exactly one cycle then return to IDLE.
REQ-019 Detected spck rise in the same cycle as ncs rise SHALL be ignored (ncs rise wins).
REQ-020 DECODE with bit_cnt == 16: opcode shift_reg[15:12]: 4'b0001 -> conf_word <= shift_reg[7:0], conf_stb; if data == 8'h01 also user_byte1 <= 8'd127 (no ub1_stb).
REQ-021 4'b0010 -> divisor <= shift_reg[7:0], div_stb; 4'b0011 -> user_byte1 <= shift_reg[7:0], ub1_stb.
REQ-022 Any other opcode SHALL change no register, raise no strobe, no frame_err.
REQ-023 DECODE with bit_cnt != 16 (short or long frame) SHALL pulse frame_err and change no register.
REQ-024 Register write and strobe SHALL appear 4 pck0 cycles after the first pck0 edge sampling ncs high at the pin (2 sync, 1 detect, 1 decode).
REQ-025 spck edges and ncs rising edges while in IDLE SHALL be ignored.
REQ-026 Input timing contract: spck high and low phases each >= 3 pck0 periods; ncs high >= 3 pck0 periods between frames.
REQ-027 shift_reg[11:8] SHALL be ignored.

Reset
REQ-028 On nreset low: state IDLE, bit_cnt 0, shift_reg 0, synchronizer/history flops 1 for ncs and 0 for spck/mosi.
REQ-029 Reset values: conf_word 8'h00, divisor 8'd95, user_byte1 8'd127, all strobes 0, frame_err 0, miso 0.
REQ-030 Reset mid-frame SHALL discard the partial frame; if ncs is low at reset release the block SHALL stay IDLE until a fresh ncs falling edge.

Structure
REQ-031 Shared package/include lf_cmd_pkg SHALL hold opcodes (CMD_SET_CONF 4'h1, CMD_SET_DIVISOR 4'h2, CMD_SET_USER_BYTE1 4'h3), reset defaults (95, 127), edge-detect conf value 8'h01, state encodings.
REQ-032 One sub-module sync_edge (2-flop sync + history, outputs level, rise, fall) SHALL be instantiated once per async input.

Verification
REQ-033 Reset, no SPI activity -> conf_word 0x00, divisor 95, user_byte1 127, miso 0, no strobes.
REQ-034 Frame 0x2060 -> divisor 0x60 and single div_stb pulse exactly 4 cycles after ncs rise; other registers unchanged.
REQ-035 Frame 0x3050 then 0x1001 -> user_byte1 0x50 with ub1_stb, then conf_word 0x01, user_byte1 127, conf_stb only.
REQ-036 15-bit and 17-bit frames of 0x1020 -> one frame_err pulse each, conf_word unchanged; frame 0x7055 -> no strobe, no error.
REQ-037 After conf_word 0x21, user_byte1 0x80: new frame reads back miso sequence 0x2180 MSB first across 16 spck rises.
REQ-038 nreset asserted after 8 bits of frame 0x20FF with ncs held low, released, ncs raised -> divisor stays 95, no strobe, no frame_err.
